regfile_sb: RTL and testbench

Parametrised register file with a per-entry scoreboard and a sequenced clear. It replaces the fixed 16x16 bank as the CPU's general-purpose register storage. It provides one synchronous write port and two combinational read ports with optional write-to-read bypass. Pending bits let the control unit stall on registers whose producer has not yet written back. Clear is a multi-cycle sweep signalled by a busy flag, not a single-cycle wipe.

---
 rtl/regfile_sb.sv | 116 +++++++++++
 tb/tb_regfile_sb.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with per-entry pending scoreboard and a one-entry-per-cycle clear sweep.
// Latency: reads combinational (optional same-cycle write bypass); writes/reserves land on the next edge.
// Backpressure: none; writes and reserves arriving while busy or with clear asserted are dropped.
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] address_w,
    input  logic [DATA_W-1:0] data_in_w,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [ADDR_W-1:0] address_b,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b,
    input  logic              reserve_enable,
    input  logic [ADDR_W-1:0] address_r,
    output logic              pending_a,
    output logic              pending_b
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic              accept, wr_ok, rs_ok;
    logic              zero_w, zero_r, zero_a, zero_b;

    always_comb begin
        zero_w = (ZERO_REG != 0) && (address_w == '0);
        zero_r = (ZERO_REG != 0) && (address_r == '0);
        zero_a = (ZERO_REG != 0) && (address_a == '0);
        zero_b = (ZERO_REG != 0) && (address_b == '0);
        accept = (state == IDLE) && !clear;
        wr_ok  = write_enable && accept && !zero_w;
        rs_ok  = reserve_enable && accept && !zero_r;
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                ptr_nxt = ptr + 1'b1;
                if (ptr == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Reserve is applied after write so a same-address reserve leaves the entry pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pend <= '0;
        end else if (state == CLEAR) begin
            mem[ptr]  <= '0;
            pend[ptr] <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[address_w]  <= data_in_w;
                pend[address_w] <= 1'b0;
            end
            if (rs_ok) begin
                pend[address_r] <= 1'b1;
            end
        end
    end

    always_comb begin
        data_out_a = zero_a ? '0 : mem[address_a];
        data_out_b = zero_b ? '0 : mem[address_b];
        if ((BYPASS != 0) && wr_ok && (address_w == address_a)) begin
            data_out_a = data_in_w;
        end
        if ((BYPASS != 0) && wr_ok && (address_w == address_b)) begin
            data_out_b = data_in_w;
        end
        pending_a = pend[address_a] && !zero_a;
        pending_b = pend[address_b] && !zero_b;
        busy      = (state == CLEAR);
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: instance 0 uses defaults (bypass on, no zero reg),
// instance 1 uses ZERO_REG=1, BYPASS=0; both share the same stimulus.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        we = 1'b0;
    logic        rs = 1'b0;
    logic [3:0]  aw = '0, ar = '0, aa = '0, ab = '0;
    logic [15:0] din = '0;
    logic [15:0] d0_a, d0_b, d1_a, d1_b;
    logic        p0_a, p0_b, p1_a, p1_b, busy0, busy1;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] m_mem  [2][16];
    bit          m_pend [2][16];
    int          m_sweep;

    always #5 clk = ~clk;

    regfile_sb u_dut0 (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy0),
        .write_enable(we), .address_w(aw), .data_in_w(din),
        .address_a(aa), .address_b(ab), .data_out_a(d0_a), .data_out_b(d0_b),
        .reserve_enable(rs), .address_r(ar), .pending_a(p0_a), .pending_b(p0_b)
    );

    regfile_sb #(.ZERO_REG(1), .BYPASS(0)) u_dut1 (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy1),
        .write_enable(we), .address_w(aw), .data_in_w(din),
        .address_a(aa), .address_b(ab), .data_out_a(d1_a), .data_out_b(d1_b),
        .reserve_enable(rs), .address_r(ar), .pending_a(p1_a), .pending_b(p1_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Reference model: array of values, array of pending flags, and a sweep index (-1 when idle).
    function automatic bit is_zero(int i, logic [3:0] addr);
        return (i == 1) && (addr == 4'd0);
    endfunction

    function automatic bit wr_taken(int i);
        return we && (m_sweep < 0) && !clear && !is_zero(i, aw);
    endfunction

    function automatic logic [15:0] exp_rd(int i, logic [3:0] addr);
        if (is_zero(i, addr)) return 16'h0;
        if ((i == 0) && wr_taken(i) && (aw == addr)) return din;
        return m_mem[i][addr];
    endfunction

    function automatic bit exp_pend(int i, logic [3:0] addr);
        if (is_zero(i, addr)) return 1'b0;
        return m_pend[i][addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 16; r++) begin
                m_mem[i][r]  = 16'h0;
                m_pend[i][r] = 1'b0;
            end
        end
        m_sweep = -1;
    endtask

    task automatic model_edge();
        if (m_sweep >= 0) begin
            for (int i = 0; i < 2; i++) begin
                m_mem[i][m_sweep]  = 16'h0;
                m_pend[i][m_sweep] = 1'b0;
            end
            m_sweep++;
            if (m_sweep == 16) m_sweep = -1;
        end else if (clear) begin
            m_sweep = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (we && !is_zero(i, aw)) begin
                    m_mem[i][aw]  = din;
                    m_pend[i][aw] = 1'b0;
                end
                if (rs && !is_zero(i, ar)) m_pend[i][ar] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        bit eb;
        eb = (m_sweep >= 0);
        chk("busy0", 32'(busy0), 32'(eb));
        chk("busy1", 32'(busy1), 32'(eb));
        chk($sformatf("i0 data_out_a[%0d]", aa), 32'(d0_a), 32'(exp_rd(0, aa)));
        chk($sformatf("i0 data_out_b[%0d]", ab), 32'(d0_b), 32'(exp_rd(0, ab)));
        chk($sformatf("i1 data_out_a[%0d]", aa), 32'(d1_a), 32'(exp_rd(1, aa)));
        chk($sformatf("i1 data_out_b[%0d]", ab), 32'(d1_b), 32'(exp_rd(1, ab)));
        chk($sformatf("i0 pending_a[%0d]", aa), 32'(p0_a), 32'(exp_pend(0, aa)));
        chk($sformatf("i0 pending_b[%0d]", ab), 32'(p0_b), 32'(exp_pend(0, ab)));
        chk($sformatf("i1 pending_a[%0d]", aa), 32'(p1_a), 32'(exp_pend(1, aa)));
        chk($sformatf("i1 pending_b[%0d]", ab), 32'(p1_b), 32'(exp_pend(1, ab)));
    endtask

    // Entered at posedge+1 with inputs applied; checks mid-cycle, then clocks the model.
    task automatic step();
        #3;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        clear = 1'b0; we = 1'b0; rs = 1'b0;
    endtask

    task automatic fill_ones();
        for (int r = 0; r < 16; r++) begin
            idle(); we = 1'b1; aw = 4'(r); din = 16'hFFFF; aa = 4'(r); ab = 4'(15 - r);
            step();
        end
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  aw;
        logic [15:0] din;
        logic        rs;
        logic [3:0]  ar;
        logic [3:0]  aa, ab;
        logic [15:0] ea0, eb0, ea1;
        logic        epa0, epa1;
    } vec_t;

    function automatic vec_t mkv(int w, int a_w, int d, int r, int a_r, int a_a, int a_b,
                                 int e_a0, int e_b0, int e_pa0, int e_a1, int e_pa1);
        vec_t v;
        v.we = 1'(w); v.aw = 4'(a_w); v.din = 16'(d); v.rs = 1'(r); v.ar = 4'(a_r);
        v.aa = 4'(a_a); v.ab = 4'(a_b);
        v.ea0 = 16'(e_a0); v.eb0 = 16'(e_b0); v.epa0 = 1'(e_pa0);
        v.ea1 = 16'(e_a1); v.epa1 = 1'(e_pa1);
        return v;
    endfunction

    vec_t tbl [13];

    initial begin
        int nb;
        int j;
        //             we aw din     rs ar aa ab  ea0     eb0     pa0 ea1     pa1
        tbl[0]  = mkv(1, 3, 'hA5A5, 0, 0, 3, 7, 'hA5A5, 'h0000, 0, 'h0000, 0);
        tbl[1]  = mkv(0, 0, 'h0000, 0, 0, 3, 3, 'hA5A5, 'hA5A5, 0, 'hA5A5, 0);
        tbl[2]  = mkv(1, 7, 'h1234, 0, 0, 7, 3, 'h1234, 'hA5A5, 0, 'h0000, 0);
        tbl[3]  = mkv(0, 0, 'h0000, 1, 5, 5, 7, 'h0000, 'h1234, 0, 'h0000, 0);
        tbl[4]  = mkv(0, 0, 'h0000, 0, 0, 5, 3, 'h0000, 'hA5A5, 1, 'h0000, 1);
        tbl[5]  = mkv(1, 5, 'h0055, 0, 0, 5, 3, 'h0055, 'hA5A5, 1, 'h0000, 1);
        tbl[6]  = mkv(0, 0, 'h0000, 0, 0, 5, 3, 'h0055, 'hA5A5, 0, 'h0055, 0);
        tbl[7]  = mkv(1, 5, 'h6666, 1, 5, 5, 3, 'h6666, 'hA5A5, 0, 'h0055, 0);
        tbl[8]  = mkv(0, 0, 'h0000, 0, 0, 5, 3, 'h6666, 'hA5A5, 1, 'h6666, 1);
        tbl[9]  = mkv(1, 0, 'hBEEF, 1, 0, 0, 5, 'hBEEF, 'h6666, 0, 'h0000, 0);
        tbl[10] = mkv(0, 0, 'h0000, 0, 0, 0, 5, 'hBEEF, 'h6666, 1, 'h0000, 0);
        tbl[11] = mkv(1, 1, 'h1111, 0, 0, 1, 5, 'h1111, 'h6666, 0, 'h0000, 0);
        tbl[12] = mkv(0, 0, 'h0000, 0, 0, 1, 5, 'h1111, 'h6666, 0, 'h1111, 0);

        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int k = 0; k < 13; k++) begin
            idle();
            we = tbl[k].we; aw = tbl[k].aw; din = tbl[k].din;
            rs = tbl[k].rs; ar = tbl[k].ar; aa = tbl[k].aa; ab = tbl[k].ab;
            #2;
            chk($sformatf("vec%0d i0 data_out_a", k), 32'(d0_a), 32'(tbl[k].ea0));
            chk($sformatf("vec%0d i0 data_out_b", k), 32'(d0_b), 32'(tbl[k].eb0));
            chk($sformatf("vec%0d i0 pending_a", k), 32'(p0_a), 32'(tbl[k].epa0));
            chk($sformatf("vec%0d i1 data_out_a", k), 32'(d1_a), 32'(tbl[k].ea1));
            chk($sformatf("vec%0d i1 pending_a", k), 32'(p1_a), 32'(tbl[k].epa1));
            step();
        end

        // Asynchronous reset between edges clears the read data at once.
        idle(); aa = 4'd3; ab = 4'd7;
        #1;
        chk("pre_reset r3", 32'(d0_a), 32'h0000A5A5);
        reset = 1'b1;
        #1;
        chk("async_reset r3 i0", 32'(d0_a), 32'h0);
        chk("async_reset r7 i0", 32'(d0_b), 32'h0);
        model_reset();
        check_all();
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Clear sweep: write in the clear cycle is dropped, busy lasts DEPTH cycles.
        fill_ones();
        idle(); clear = 1'b1; we = 1'b1; aw = 4'd9; din = 16'h1234; aa = 4'd9; ab = 4'd4;
        #1;
        chk("clear_cycle r9 not bypassed", 32'(d0_a), 32'h0000FFFF);
        step();
        nb = 0;
        j = 0;
        while (j < 40) begin
            idle(); we = (j == 5); aw = 4'd9; din = 16'h1234;
            aa = (j == 4) ? 4'd3 : 4'd9; ab = 4'd4;
            #2;
            if (!busy0) break;
            nb++;
            if (j == 4) begin
                chk("sweep4 r3", 32'(d0_a), 32'h0);
                chk("sweep4 r4", 32'(d0_b), 32'h0000FFFF);
            end
            step();
            j++;
        end
        chk("busy_length", 32'(nb), 32'd16);
        we = 1'b1; aw = 4'd9; din = 16'h9999; aa = 4'd9;
        #1;
        chk("post_sweep bypass r9 i0", 32'(d0_a), 32'h00009999);
        chk("post_sweep stored r9 i1", 32'(d1_a), 32'h0);
        step();
        idle(); aa = 4'd9;
        #1;
        chk("post_sweep write r9 i0", 32'(d0_a), 32'h00009999);
        chk("post_sweep write r9 i1", 32'(d1_a), 32'h00009999);
        step();

        // Reset in the middle of a sweep; the sweep must not resume.
        fill_ones();
        idle(); clear = 1'b1;
        step();
        for (int s = 0; s < 6; s++) begin
            idle(); aa = 4'(s); ab = 4'd10;
            step();
        end
        idle(); aa = 4'd10; ab = 4'd2;
        #1;
        chk("midsweep r10 before reset", 32'(d0_a), 32'h0000FFFF);
        reset = 1'b1;
        #1;
        chk("midsweep reset r10", 32'(d0_a), 32'h0);
        chk("midsweep reset busy", 32'(busy0), 32'h0);
        model_reset();
        check_all();
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        idle(); we = 1'b1; aw = 4'd10; din = 16'h0A0A; aa = 4'd10;
        step();
        for (int r = 0; r < 16; r++) begin
            idle(); aa = 4'(r); ab = 4'(15 - r);
            step();
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            clear = ($urandom_range(0, 59) == 0);
            we    = 1'($urandom);
            aw    = 4'($urandom);
            din   = 16'($urandom);
            rs    = ($urandom_range(0, 2) == 0);
            ar    = ($urandom_range(0, 3) == 0) ? aw : 4'($urandom);
            aa    = ($urandom_range(0, 2) == 0) ? aw : 4'($urandom);
            ab    = ($urandom_range(0, 2) == 0) ? ar : 4'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
